// File: rtl/softmax_stream_driver.sv
// softmax_stream_driver
//
// Host-side sequencer for one dtom_softmax engine. It buffers one input
// vector from the host, pulses the engine Start, streams the vector on
// Datain, collects the reversed result stream into a result buffer and
// drains it to the host over a valid/ready port. It aborts with a sticky
// Err if the engine never answers.
//
// Ports
//   Clock, Reset_n          single rising-edge clock, async active-low reset
//   Load_vld/data/rdy       host writes input words, index 0 first
//   Go, Len                 launch a transaction of Len+1 words (IDLE only)
//   Start, Datain, N        engine start pulse, input word, held length
//   Dataout, Dataout_vld    engine result stream (highest index first)
//   Res_data/vld/rdy        result words to the host, index 0 first
//   Busy, Done, Err         status: not idle, last word taken, timeout

module softmax_stream_driver #(
    parameter int BITWIDTH = 32,
    parameter int INPUTMAX = 2,
    parameter int TIMEOUT  = 4096
) (
    input  logic                Clock,
    input  logic                Reset_n,
    input  logic                Load_vld,
    input  logic [BITWIDTH-1:0] Load_data,
    output logic                Load_rdy,
    input  logic                Go,
    input  logic [INPUTMAX:0]   Len,
    output logic                Start,
    output logic [BITWIDTH-1:0] Datain,
    output logic [INPUTMAX:0]   N,
    input  logic [BITWIDTH-1:0] Dataout,
    input  logic                Dataout_vld,
    output logic [BITWIDTH-1:0] Res_data,
    output logic                Res_vld,
    input  logic                Res_rdy,
    output logic                Busy,
    output logic                Done,
    output logic                Err
);

    localparam int CAP = 2 ** INPUTMAX;
    localparam int LW  = INPUTMAX + 1;
    localparam int IW  = INPUTMAX;
    localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_SEND  = 3'd2,
        S_WAIT  = 3'd3,
        S_RECV  = 3'd4,
        S_DRAIN = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [LW-1:0]         ptr_q, ptr_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [IW-1:0]         rcnt_q, rcnt_d;
    logic [IW-1:0]         didx_q, didx_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [LW-1:0]         n_q, n_d;
    logic                  err_q, err_d;
    logic                  load_rdy_q, load_rdy_d;
    logic [BITWIDTH-1:0]   in_buf_q [CAP];
    logic [BITWIDTH-1:0]   in_buf_d [CAP];
    logic [BITWIDTH-1:0]   res_buf_q [CAP];
    logic [BITWIDTH-1:0]   res_buf_d [CAP];
    logic [IW-1:0]         n_idx;

    // n_q is clamped to CAP-1 at Go, so its low bits are a valid buffer index
    assign n_idx = n_q[IW-1:0];

    // Next-state and datapath. The buffers are plain register arrays so all
    // reads are combinational by index.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        rcnt_d    = rcnt_q;
        didx_d    = didx_q;
        timer_d   = timer_q;
        n_d       = n_q;
        err_d     = err_q;
        in_buf_d  = in_buf_q;
        res_buf_d = res_buf_q;
        Start     = 1'b0;
        Datain    = '0;
        Res_vld   = 1'b0;
        Res_data  = '0;
        Done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A load beat in the same cycle as Go is still written
                if (Load_vld && load_rdy_q) begin
                    in_buf_d[ptr_q[IW-1:0]] = Load_data;
                    ptr_d = ptr_q + LW'(1);
                end
                if (Go) begin
                    n_d     = (Len > LW'(CAP - 1)) ? LW'(CAP - 1) : Len;
                    err_d   = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                Start   = 1'b1;
                idx_d   = '0;
                state_d = S_SEND;
            end
            S_SEND: begin
                Datain = in_buf_q[idx_q];
                if (idx_q == n_idx) begin
                    timer_d = '0;
                    state_d = S_WAIT;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_WAIT: begin
                timer_d = timer_q + TW'(1);
                if (Dataout_vld) begin
                    // First returned word belongs at the top of the vector.
                    // A one-word vector is already complete here.
                    res_buf_d[n_idx] = Dataout;
                    if (n_idx == '0) begin
                        didx_d  = '0;
                        state_d = S_DRAIN;
                    end else begin
                        rcnt_d  = IW'(1);
                        state_d = S_RECV;
                    end
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    ptr_d   = '0;
                    state_d = S_IDLE;
                end
            end
            S_RECV: begin
                if (Dataout_vld) begin
                    res_buf_d[n_idx - rcnt_q] = Dataout;
                    if (rcnt_q == n_idx) begin
                        didx_d  = '0;
                        state_d = S_DRAIN;
                    end else begin
                        rcnt_d = rcnt_q + IW'(1);
                    end
                end
            end
            S_DRAIN: begin
                Res_vld  = 1'b1;
                Res_data = res_buf_q[didx_q];
                if (Res_rdy) begin
                    if (didx_q == n_idx) begin
                        Done    = 1'b1;
                        ptr_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        didx_d = didx_q + IW'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Load_rdy is registered from the next state so that it is 0 in
        // reset and drops the cycle after Go; it therefore rises one cycle
        // after reset release.
        load_rdy_d = (state_d == S_IDLE) && (ptr_d < LW'(CAP));
    end

    // Control registers with asynchronous reset
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            idx_q      <= '0;
            rcnt_q     <= '0;
            didx_q     <= '0;
            timer_q    <= '0;
            n_q        <= '0;
            err_q      <= 1'b0;
            load_rdy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            idx_q      <= idx_d;
            rcnt_q     <= rcnt_d;
            didx_q     <= didx_d;
            timer_q    <= timer_d;
            n_q        <= n_d;
            err_q      <= err_d;
            load_rdy_q <= load_rdy_d;
        end
    end

    // Buffer contents are don't-care after reset, so they carry no reset
    always_ff @(posedge Clock) begin
        in_buf_q  <= in_buf_d;
        res_buf_q <= res_buf_d;
    end

    assign Load_rdy = load_rdy_q;
    assign N        = n_q;
    assign Err      = err_q;
    assign Busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_softmax_stream_driver.sv
// tb_softmax_stream_driver
//
// Self-checking bench for softmax_stream_driver (TIMEOUT shortened to 16).
// A table of transaction shapes is run with random data and random engine
// and host timing; the expected Datain stream is the loaded vector and the
// expected result stream is the engine's response stream in reverse order.
// Hand-written sequences cover the fixed-data launch, backpressure, timeout
// and asynchronous reset.

module tb_softmax_stream_driver;

    localparam int BW = 32;
    localparam int IM = 2;
    localparam int TO = 16;

    logic          Clock;
    logic          Reset_n;
    logic          Load_vld;
    logic [BW-1:0] Load_data;
    logic          Load_rdy;
    logic          Go;
    logic [IM:0]   Len;
    logic          Start;
    logic [BW-1:0] Datain;
    logic [IM:0]   N;
    logic [BW-1:0] Dataout;
    logic          Dataout_vld;
    logic [BW-1:0] Res_data;
    logic          Res_vld;
    logic          Res_rdy;
    logic          Busy;
    logic          Done;
    logic          Err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0] len;
        int         exp_n;
        bit         rdy_rand;
        bit         vld_gaps;
        bit         go_with_load;
        bit         junk_vld;
    } vec_t;

    softmax_stream_driver #(
        .BITWIDTH (BW),
        .INPUTMAX (IM),
        .TIMEOUT  (TO)
    ) dut (
        .Clock       (Clock),
        .Reset_n     (Reset_n),
        .Load_vld    (Load_vld),
        .Load_data   (Load_data),
        .Load_rdy    (Load_rdy),
        .Go          (Go),
        .Len         (Len),
        .Start       (Start),
        .Datain      (Datain),
        .N           (N),
        .Dataout     (Dataout),
        .Dataout_vld (Dataout_vld),
        .Res_data    (Res_data),
        .Res_vld     (Res_vld),
        .Res_rdy     (Res_rdy),
        .Busy        (Busy),
        .Done        (Done),
        .Err         (Err)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Hard stop in case a bounded wait was missed somewhere
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running required finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h required 0x%08h", name, actual, expected);
        end
    endtask

    // Writes nw words, waiting (bounded) for Load_rdy on each
    task automatic loadWords(input logic [31:0] w [4], input int nw);
        int guard;
        for (int i = 0; i < nw; i++) begin
            @(negedge Clock);
            Load_vld  = 1'b1;
            Load_data = w[i];
            #1;
            guard = 0;
            while (Load_rdy !== 1'b1 && guard < 20) begin
                @(negedge Clock);
                #1;
                guard++;
            end
            if (guard >= 20) checkOutput("load_rdy_wait", 32'(Load_rdy), 32'd1);
        end
        @(negedge Clock);
        Load_vld = 1'b0;
    endtask

    // One full transaction: load, Go, send, engine reply, drain
    task automatic applyStimulus(input logic [2:0] len, input int exp_n,
                                 input logic [31:0] w [4], input logic [31:0] r [4],
                                 input logic [15:0] rdy_pat, input logic [3:0] gap_pat,
                                 input int wait_dly, input bit go_with_load,
                                 input bit junk_vld);
        int guard;
        int j;
        loadWords(w, go_with_load ? exp_n : exp_n + 1);

        // Cycle 0: Go accept
        @(negedge Clock);
        if (go_with_load) begin
            Load_vld  = 1'b1;
            Load_data = w[exp_n];
        end
        Go  = 1'b1;
        Len = len;
        #1;
        checkOutput("idle_busy", 32'(Busy), 32'd0);
        if (go_with_load) checkOutput("go_load_rdy", 32'(Load_rdy), 32'd1);

        // Cycle 1: Start
        @(negedge Clock);
        Go       = 1'b0;
        Load_vld = 1'b0;
        Len      = 3'($urandom);
        #1;
        checkOutput("start_pulse", 32'(Start), 32'd1);
        checkOutput("n_latched", 32'(N), 32'(exp_n));
        checkOutput("err_cleared", 32'(Err), 32'd0);
        checkOutput("load_rdy_busy", 32'(Load_rdy), 32'd0);

        // Cycles 2..N+2: Datain stream, engine chatter must be ignored
        for (int i = 0; i <= exp_n; i++) begin
            @(negedge Clock);
            Dataout_vld = junk_vld;
            Dataout     = $urandom;
            #1;
            checkOutput("datain", Datain, w[i]);
            checkOutput("start_once", 32'(Start), 32'd0);
            checkOutput("n_stable", 32'(N), 32'(exp_n));
        end

        // WAIT, then engine replies highest index first
        for (int d = 0; d < wait_dly; d++) begin
            @(negedge Clock);
            Dataout_vld = 1'b0;
            #1;
            checkOutput("wait_datain", Datain, 32'd0);
            checkOutput("wait_busy", 32'(Busy), 32'd1);
        end
        for (int k = 0; k <= exp_n; k++) begin
            if (gap_pat[k]) begin
                @(negedge Clock);
                Dataout_vld = 1'b0;
                Dataout     = $urandom;
                #1;
                checkOutput("recv_res_vld", 32'(Res_vld), 32'd0);
            end
            @(negedge Clock);
            Dataout_vld = 1'b1;
            Dataout     = r[k];
            #1;
            checkOutput("recv_res_vld", 32'(Res_vld), 32'd0);
        end

        // DRAIN: host index j gets the reply that came out in position N-j
        j     = 0;
        guard = 0;
        while (j <= exp_n && guard < 40) begin
            @(negedge Clock);
            Dataout_vld = 1'b0;
            Res_rdy     = (guard < 16) ? rdy_pat[guard] : 1'b1;
            #1;
            checkOutput("res_vld", 32'(Res_vld), 32'd1);
            checkOutput("res_data", Res_data, r[exp_n - j]);
            checkOutput("done", 32'(Done), 32'(Res_rdy && (j == exp_n)));
            if (Res_rdy) j++;
            guard++;
        end
        if (j <= exp_n) checkOutput("drain_words", 32'(j), 32'(exp_n + 1));

        @(negedge Clock);
        Res_rdy = 1'b0;
        #1;
        checkOutput("post_busy", 32'(Busy), 32'd0);
        checkOutput("post_done", 32'(Done), 32'd0);
        checkOutput("post_res_vld", 32'(Res_vld), 32'd0);
        checkOutput("post_load_rdy", 32'(Load_rdy), 32'd1);
    endtask

    initial begin
        vec_t        vecs [8];
        logic [31:0] w [4];
        logic [31:0] r [4];
        logic [2:0]  rl;

        vecs[0] = '{3'd3, 3, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{3'd0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{3'd7, 3, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{3'd1, 1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{3'd2, 2, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{3'd5, 3, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[6] = '{3'd0, 0, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[7] = '{3'd4, 3, 1'b1, 1'b1, 1'b0, 1'b0};

        Reset_n     = 1'b0;
        Load_vld    = 1'b0;
        Load_data   = '0;
        Go          = 1'b0;
        Len         = '0;
        Dataout     = '0;
        Dataout_vld = 1'b0;
        Res_rdy     = 1'b0;

        // Reset values
        #12;
        checkOutput("rst_load_rdy", 32'(Load_rdy), 32'd0);
        checkOutput("rst_start", 32'(Start), 32'd0);
        checkOutput("rst_datain", Datain, 32'd0);
        checkOutput("rst_n", 32'(N), 32'd0);
        checkOutput("rst_res_vld", 32'(Res_vld), 32'd0);
        checkOutput("rst_res_data", Res_data, 32'd0);
        checkOutput("rst_busy", 32'(Busy), 32'd0);
        checkOutput("rst_done", 32'(Done), 32'd0);
        checkOutput("rst_err", 32'(Err), 32'd0);
        @(negedge Clock);
        Reset_n = 1'b1;

        // Fixed launch with N = 3, host always ready
        w = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        r = '{32'h3E800000, 32'h3E000000, 32'h3D800000, 32'h3F000000};
        applyStimulus(3'd3, 3, w, r, 16'hFFFF, 4'h0, 2, 1'b0, 1'b0);

        // Backpressure 1,0,0,1 then ready
        w = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        r = '{32'hAAAA0000, 32'hBBBB0000, 32'hCCCC0000, 32'hDDDD0000};
        applyStimulus(3'd3, 3, w, r, 16'hFFF9, 4'h0, 0, 1'b0, 1'b0);

        // Table of shapes with random data and timing
        foreach (vecs[v]) begin
            for (int i = 0; i < 4; i++) begin
                w[i] = $urandom;
                r[i] = $urandom;
            end
            applyStimulus(vecs[v].len, vecs[v].exp_n, w, r,
                          vecs[v].rdy_rand ? 16'($urandom) : 16'hFFFF,
                          vecs[v].vld_gaps ? 4'($urandom) : 4'h0,
                          $urandom_range(0, 6), vecs[v].go_with_load,
                          vecs[v].junk_vld);
        end

        // Fully random transactions; length rule is clamp to capacity-1
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 4; i++) begin
                w[i] = $urandom;
                r[i] = $urandom;
            end
            rl = 3'($urandom);
            applyStimulus(rl, (int'(rl) > 3) ? 3 : int'(rl), w, r, 16'($urandom),
                          4'($urandom), $urandom_range(0, 6), 1'($urandom),
                          1'($urandom));
        end

        // Timeout: engine silent, Err rises 16 cycles after WAIT entry
        w = '{32'h01010101, 32'h02020202, 32'h0, 32'h0};
        loadWords(w, 2);
        @(negedge Clock);
        Go  = 1'b1;
        Len = 3'd1;
        @(negedge Clock);
        Go = 1'b0;
        #1;
        checkOutput("to_start", 32'(Start), 32'd1);
        repeat (2) @(negedge Clock);
        for (int c = 0; c < TO; c++) begin
            @(negedge Clock);
            #1;
            checkOutput("to_err_low", 32'(Err), 32'd0);
            checkOutput("to_busy", 32'(Busy), 32'd1);
            checkOutput("to_no_done", 32'(Done), 32'd0);
        end
        @(negedge Clock);
        #1;
        checkOutput("to_err_set", 32'(Err), 32'd1);
        checkOutput("to_idle", 32'(Busy), 32'd0);
        checkOutput("to_no_done_end", 32'(Done), 32'd0);
        checkOutput("to_load_rdy", 32'(Load_rdy), 32'd1);
        repeat (3) begin
            @(negedge Clock);
            #1;
            checkOutput("to_err_sticky", 32'(Err), 32'd1);
        end
        for (int i = 0; i < 4; i++) begin
            w[i] = $urandom;
            r[i] = $urandom;
        end
        applyStimulus(3'd2, 2, w, r, 16'hFFFF, 4'h0, 1, 1'b0, 1'b0);

        // Async reset in the middle of SEND
        w = '{32'h0A0A0A0A, 32'h0B0B0B0B, 32'h0C0C0C0C, 32'h0D0D0D0D};
        loadWords(w, 4);
        @(negedge Clock);
        Go  = 1'b1;
        Len = 3'd3;
        @(negedge Clock);
        Go = 1'b0;
        @(negedge Clock);
        @(negedge Clock);
        #1;
        checkOutput("ar_datain_before", Datain, 32'h0B0B0B0B);
        checkOutput("ar_busy_before", 32'(Busy), 32'd1);
        #2;
        Reset_n = 1'b0;
        #1;
        checkOutput("ar_busy", 32'(Busy), 32'd0);
        checkOutput("ar_start", 32'(Start), 32'd0);
        checkOutput("ar_datain", Datain, 32'd0);
        checkOutput("ar_n", 32'(N), 32'd0);
        checkOutput("ar_load_rdy", 32'(Load_rdy), 32'd0);
        @(negedge Clock);
        Reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            w[i] = $urandom;
            r[i] = $urandom;
        end
        applyStimulus(3'd3, 3, w, r, 16'($urandom), 4'h5, 3, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/softmax_stream_driver.md
# softmax_stream_driver

Host-side counterpart of the `dtom_softmax` engine. It buffers one input vector from the host and issues the engine's `Start` pulse. It then streams the vector on `Datain`, collects the returning probability stream from `Dataout`/`Dataout_vld` into a result buffer, and drains the results to the host over a valid/ready port. It sits between the host/DMA logic and one softmax engine instance, and it owns the engine's whole transaction sequencing, including the no-response timeout.

## Interface
- `BITWIDTH`, 32, word width (IEEE-754 single on both sides; the block does not interpret the data).
- `INPUTMAX`, 2, vector capacity is `2**INPUTMAX` words; the length field is `INPUTMAX+1` bits.
- `TIMEOUT`, 4096, maximum number of cycles to wait for the first `Dataout_vld` before the transaction is aborted.
- `Clock` in 1: single clock; all logic is on the rising edge.
- `Reset_n` in 1: asynchronous, active-low reset, released synchronously to `Clock` upstream.
- `Load_vld` in 1, `Load_data` in `BITWIDTH`, `Load_rdy` out 1: host writes input vector words into the input buffer, index 0 first.
- `Go` in 1: pulse that launches a transaction. It is honoured only in IDLE.
- `Len` in `INPUTMAX+1`: number of words minus 1 (the `N` convention), sampled when `Go` is accepted.
- `Start` out 1: one-cycle start pulse to the engine.
- `Datain` out `BITWIDTH`: input word to the engine.
- `N` out `INPUTMAX+1`: registered length to the engine, held stable for the whole transaction.
- `Dataout` in `BITWIDTH`, `Dataout_vld` in 1: engine result stream.
- `Res_data` out `BITWIDTH`, `Res_vld` out 1, `Res_rdy` in 1: result words to the host, index 0 first.
- `Busy` out 1: high in every state except IDLE.
- `Done` out 1: one-cycle pulse when the last result word is accepted by the host.
- `Err` out 1: sticky timeout flag, cleared by the next accepted `Go`.

## Operation
- **Reset values.**
  - All outputs are 0.
  - `N` is 0 and `Datain` is 0.
  - State is IDLE and the load pointer is 0.
  - Buffer contents are don't-care.
- **IDLE.**
  - `Load_rdy` is 1 while the load pointer is below `2**INPUTMAX`.
  - On `Load_vld && Load_rdy`: write the word to `InBuf[ptr]` and increment `ptr`.
  - On `Go`: latch `N <= Len`, clear `Err`, go to START.
  - If `Len > 2**INPUTMAX-1`, clamp `Len` to `2**INPUTMAX-1`.
  - If `Go` and a load beat occur in the same cycle, the load beat is still written, and `Load_rdy` is 0 from the next cycle.
- **START.** Assert `Start` for exactly one cycle, reset the send index to 0, go to SEND.
- **SEND.**
  - Drive `Datain = InBuf[idx]` for one cycle per word, `idx = 0..N`. `N+1` words total, no gaps.
  - After word `N`, clear the timeout counter and go to WAIT.
  - `Datain` returns to 0 outside SEND.
- **WAIT.**
  - Increment the timeout counter every cycle.
  - If `Dataout_vld` is 1: capture the first word and go to RECV.
  - If the counter reaches `TIMEOUT-1` without `Dataout_vld`: set `Err`, reset the load pointer, go to IDLE. No `Done` is issued.
- **RECV.**
  - The engine returns `N+1` words, highest index first, with `Dataout_vld` high on each.
  - Return word `k` (k = 0..N) is written to `ResBuf[N-k]`.
  - Cycles where `Dataout_vld` is 0 are ignored; RECV has no timeout.
  - After `N+1` captures, set the drain index to 0 and go to DRAIN.
  - `Dataout_vld` seen outside WAIT/RECV is ignored.
- **DRAIN.**
  - `Res_vld` is 1 and `Res_data = ResBuf[didx]`.
  - `didx` advances on `Res_vld && Res_rdy`.
  - On acceptance of word `N`: pulse `Done`, reset the load pointer, go to IDLE.
  - `Res_data` holds its value while `Res_rdy` is 0.
- **Illegal state encoding:** go to IDLE on the next clock.
- **Reset mid-operation:** `Reset_n` low in any state forces the reset values immediately (asynchronously). A partially sent vector is abandoned. The engine is reset by its own reset.

## Timing
- Cycle 0 is the `Go` accept edge.
  - `Start` is high in cycle 1.
  - `Datain` carries word 0 in cycle 2 and word `N` in cycle `N+2`.
  - WAIT begins in cycle `N+3`.
- The first `Res_vld` is asserted one cycle after the last capture.
- `Done` is asserted in the same cycle as the final `Res_vld && Res_rdy`, and the block is back in IDLE the cycle after.
- Minimum turnaround between `Done` and the next `Start` is 2 cycles: one `Go` cycle, then START.
- Buffers are register arrays written and read combinationally by index; there is no read latency.

## Test plan
- **Load and launch, N = 3.** Load 0x3F800000, 0x40000000, 0x40400000, 0x40800000, pulse `Go`.
  - Required: `Start` for one cycle, then `Datain` carries those 4 words on consecutive cycles, `N` = 3.
- **Reverse capture.** Engine model returns A, B, C, D with `Dataout_vld` high.
  - Required: `Res_data` sequence D, C, B, A with `Res_rdy` tied 1, and `Done` on the 4th beat.
- **Backpressure.** `Res_rdy` toggles 1, 0, 0, 1 during DRAIN.
  - Required: `Res_data` stable while not ready, no word lost or duplicated, `Done` only on the final accepted beat.
- **Timeout.** `TIMEOUT` = 16 and the engine never responds.
  - Required: `Err` = 1 in cycle 16 after WAIT entry, block returns to IDLE, no `Done`; the next `Go` clears `Err`.
- **Length edges.** `Len` = 0 gives a 1-word send, 1-word receive and `Done`. `Len` = 7 with `INPUTMAX` = 2 is clamped to 3 (4 words sent).
- **Async reset.** Assert `Reset_n` low in the middle of SEND.
  - Required: `Busy`, `Start` and `Datain` go to 0 without waiting for a clock edge; a subsequent full transaction completes correctly.
